text_buffer_arbiter: RTL and testbench
======================================

TEXT_BUFFER_ARBITER -- requirements
Module: text_buffer_arbiter

Interface
REQ-001 Parameter NUM_CHARS, default 64: character cells, 4 rows x 16 columns.
REQ-002 Parameter CLEAR_CHAR, default 8'h20: fill value written by the clear sequence.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 resetn  input  1  reset; asynchronous, active-low.
REQ-005 charAddress  input  6  read address from the text engine: {row[1:0], column[3:0]}.
REQ-006 charOutput  output  8  character code at charAddress, registered.
REQ-007 clearReq  input  1  single-cycle pulse requesting a full-buffer clear.
REQ-008 busy  output  1  high while the clear sequence runs.
REQ-009 req0 / req1  input  1 each  write request from writer 0 / writer 1.
REQ-010 addr0 / addr1  input  6 each  write cell address; valid while the matching req is high.
REQ-011 data0 / data1  input  8 each  write character code; valid while the matching req is high.
REQ-012 ack0 / ack1  output  1 each  one-cycle pulse; the write was committed on this edge.

Function
REQ-013 The block SHALL hold the character memory and SHALL be the only agent that writes it.
REQ-014 The FSM SHALL have exactly two states: CLEAR and RUN.
REQ-015 In CLEAR, the block SHALL write CLEAR_CHAR to cell clrCnt on each edge, with clrCnt incrementing 0..NUM_CHARS-1.
REQ-016 After the edge that writes cell NUM_CHARS-1, the block SHALL enter RUN with clrCnt = 0.
REQ-017 In CLEAR, busy SHALL be 1, ack0 and ack1 SHALL be 0, and requests SHALL be held off without being lost.
REQ-018 In RUN, busy SHALL be 0, and at most one write per edge SHALL be committed.
REQ-019 Arbitration:
- If only one req is high, that port SHALL be granted.
- If both are high, the port not recorded in lastGrant SHALL be granted (round-robin).
- lastGrant SHALL update to the granted port.
REQ-020 A grant SHALL write data to addr on that edge and SHALL register ack = 1 for exactly the following cycle.
REQ-021 Writers SHALL hold req/addr/data stable until ack is seen. A req still high in the ack cycle SHALL be treated as a new request.
REQ-022 To prevent double-grant, the port being acked SHALL NOT be granted again in its ack cycle.
REQ-023 Read port:
- charOutput SHALL equal mem[charAddress] sampled at the previous edge: 1-cycle latency, in both states.
- On a same-cycle read/write to the same cell, the read SHALL return the old data (read-first).
REQ-024 clearReq high in RUN SHALL move the FSM to CLEAR on the next edge, with clrCnt = 0. A write granted on that same edge SHALL still commit and ack.
REQ-025 clearReq while already in CLEAR SHALL be ignored; the counter SHALL NOT restart.
REQ-026 All 6-bit addresses are legal. No range check SHALL be applied, and character validity is left to the text engine.

Reset
REQ-027 On resetn low:
- state = CLEAR, clrCnt = 0, lastGrant = 1 (port 0 wins the first tie).
- charOutput = 8'h00, ack0 = ack1 = 0, busy = 1.
REQ-028 Memory contents SHALL NOT be reset directly. The post-reset CLEAR sequence SHALL initialise them within NUM_CHARS edges.
REQ-029 Reset asserted mid-clear or mid-write SHALL abandon the operation, and the clear SHALL restart from cell 0 after release.

Structure
REQ-030 Shared package text_pkg SHALL hold:
- CHAR_ADDR_W = 6, CHAR_W = 8, NUM_CHARS = 64, CLEAR_CHAR = 8'h20.
- The FSM state type {CLEAR, RUN}.
REQ-031 The storage SHALL be one sub-module, text_char_ram: one write port, one synchronous read port, read-first, no reset.
REQ-032 Arbitration, the FSM and the ack registers SHALL live in text_buffer_arbiter.

Verification
REQ-033 Reset release:
- busy = 1 for exactly 64 cycles, then 0.
- Reading all 64 addresses afterwards returns 8'h20.
- No ack during the clear.
REQ-034 Single writer: req0 = 1, addr0 = 6'd17, data0 = "A" in RUN -> ack0 pulses one cycle; charAddress = 17 then returns 8'h41 one cycle later.
REQ-035 Tie from reset: req0 and req1 high together, held after ack:
- Grants alternate 0, 1, 0, 1.
- Each ack lasts one cycle.
- Final cell contents match the last grant per address.
REQ-036 Clear during traffic:
- clearReq pulse while req1 is pending.
- req1 is granted on the same edge if it wins, otherwise held until after 64 clear cycles.
- busy = 1 for 64 cycles.
REQ-037 Read-first: write "Z" to cell 5 while charAddress = 5 -> charOutput shows the old value next cycle and "Z" the cycle after.
REQ-038 Reset mid-clear: assert resetn low at clear cycle 30 -> after release, busy = 1 for a full 64 cycles and all cells = 8'h20.

Source files
------------

// File: rtl/text_pkg.sv
// Shared definitions for the text buffer: character geometry, the clear
// fill value and the buffer FSM state type.
package text_pkg;

  localparam int CHAR_ADDR_W = 6;                 // {row[1:0], column[3:0]}
  localparam int CHAR_W      = 8;                 // one character code
  localparam int NUM_CHARS   = 64;                // 4 rows x 16 columns
  localparam logic [CHAR_W-1:0] CLEAR_CHAR = 8'h20;

  // CLEAR: the buffer is being filled with CLEAR_CHAR, writers held off.
  // RUN:   normal operation, writers arbitrated round-robin.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/text_char_ram.sv
// Character storage: one write port and one synchronous, read-first read port.
//   clk     : clock
//   rst_n   : async active-low reset (clears only the read data register)
//   wr_en   : write strobe
//   wr_addr : write cell address
//   wr_data : write character code
//   rd_addr : read cell address
//   rd_data : registered character at rd_addr as sampled on the previous edge
module text_char_ram
  import text_pkg::*;
#(
  parameter int DEPTH = NUM_CHARS,
  parameter int AW    = CHAR_ADDR_W,
  parameter int DW    = CHAR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_data_d;
  logic [DW-1:0] rd_data_q;

  always_comb begin
    rd_data_d = mem[rd_addr];
  end

  // NOTE: the array has no reset so it maps onto plain RAM; its contents are
  // initialised by the clear sequence instead.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read and write both sample on the same edge, so a same-cell access
  // returns the old contents (read-first).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/text_buffer_arbiter.sv
// Text buffer with a two-writer round-robin arbiter and a clear sequencer.
// The block is the only agent that writes the character memory.
//   clk          : clock, all state on the rising edge
//   resetn       : async active-low reset
//   charAddress  : read address from the text engine
//   charOutput   : registered character at charAddress (1-cycle latency)
//   clearReq     : pulse requesting a full-buffer clear (ignored while clearing)
//   busy         : high while the clear sequence runs
//   req*/addr*/data* : write requests from writer 0 / writer 1
//   ack*         : one-cycle pulse, the write committed on the previous edge
module text_buffer_arbiter #(
  parameter int NUM_CHARS = text_pkg::NUM_CHARS,
  parameter logic [text_pkg::CHAR_W-1:0] CLEAR_CHAR = text_pkg::CLEAR_CHAR
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic [text_pkg::CHAR_ADDR_W-1:0] charAddress,
  output logic [text_pkg::CHAR_W-1:0]      charOutput,
  input  logic                             clearReq,
  output logic                             busy,
  input  logic                             req0,
  input  logic                             req1,
  input  logic [text_pkg::CHAR_ADDR_W-1:0] addr0,
  input  logic [text_pkg::CHAR_ADDR_W-1:0] addr1,
  input  logic [text_pkg::CHAR_W-1:0]      data0,
  input  logic [text_pkg::CHAR_W-1:0]      data1,
  output logic                             ack0,
  output logic                             ack1
);

  import text_pkg::*;

  localparam logic [CHAR_ADDR_W-1:0] LAST_CELL = CHAR_ADDR_W'(NUM_CHARS - 1);

  state_e                  state_q, state_d;
  logic [CHAR_ADDR_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic                    last_grant_q, last_grant_d;   // 1 = port 1 granted last
  logic                    ack0_q, ack0_d;
  logic                    ack1_q, ack1_d;

  logic                    elig0, elig1;
  logic                    grant0, grant1;
  logic                    wr_en;
  logic [CHAR_ADDR_W-1:0]  wr_addr;
  logic [CHAR_W-1:0]       wr_data;

  // Arbitration. A port in its ack cycle is not eligible, otherwise a writer
  // still holding req while it sees ack would be granted twice.
  // NOTE: every output of a combinational block is given a default first so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    elig0  = req0 & ~ack0_q;
    elig1  = req1 & ~ack1_q;
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == RUN) begin
      if (elig0 && elig1) begin
        grant0 = last_grant_q;
        grant1 = ~last_grant_q;
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
  end

  // Next state and write-port steering.
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    last_grant_d = last_grant_q;
    ack0_d       = grant0;
    ack1_d       = grant1;
    wr_en        = 1'b0;
    wr_addr      = clr_cnt_q;
    wr_data      = CLEAR_CHAR;

    unique case (state_q)
      CLEAR: begin
        // clearReq is ignored here: the sweep never restarts.
        wr_en = 1'b1;
        if (clr_cnt_q == LAST_CELL) begin
          state_d   = RUN;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (grant0) begin
          wr_en        = 1'b1;
          wr_addr      = addr0;
          wr_data      = data0;
          last_grant_d = 1'b0;
        end else if (grant1) begin
          wr_en        = 1'b1;
          wr_addr      = addr1;
          wr_data      = data1;
          last_grant_d = 1'b1;
        end
        // A write granted on the same edge still commits and acks.
        if (clearReq) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= CLEAR;
      clr_cnt_q    <= '0;
      last_grant_q <= 1'b1;    // port 0 wins the first tie
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      last_grant_q <= last_grant_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
    end
  end

  assign busy = (state_q == CLEAR);
  assign ack0 = ack0_q;
  assign ack1 = ack1_q;

  text_char_ram #(
    .DEPTH (NUM_CHARS),
    .AW    (CHAR_ADDR_W),
    .DW    (CHAR_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (resetn),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (charAddress),
    .rd_data (charOutput)
  );

endmodule

// File: tb/tb_text_buffer_arbiter.sv
// Self-checking bench for text_buffer_arbiter: reset/clear timing, a table of
// arbitration vectors, read-first, clear during traffic and reset mid-clear.
// Read data is checked through a scoreboard queue against a bench memory model.
module tb_text_buffer_arbiter;

  logic       clk;
  logic       resetn;
  logic [5:0] charAddress;
  logic [7:0] charOutput;
  logic       clearReq;
  logic       busy;
  logic       req0, req1;
  logic [5:0] addr0, addr1;
  logic [7:0] data0, data1;
  logic       ack0, ack1;

  int checks   = 0;
  int failures = 0;

  logic [7:0] model_mem [64];
  logic [7:0] rd_q [$];

  typedef struct {
    string      name;
    logic       r0;
    logic [5:0] a0;
    logic [7:0] d0;
    logic       r1;
    logic [5:0] a1;
    logic [7:0] d1;
    logic       e_ack0;
    logic       e_ack1;
  } vec_t;

  vec_t vecs [$];

  text_buffer_arbiter dut (
    .clk         (clk),
    .resetn      (resetn),
    .charAddress (charAddress),
    .charOutput  (charOutput),
    .clearReq    (clearReq),
    .busy        (busy),
    .req0        (req0),
    .req1        (req1),
    .addr0       (addr0),
    .addr1       (addr1),
    .data0       (data0),
    .data1       (data1),
    .ack0        (ack0),
    .ack1        (ack1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name,
                              input logic r0, input logic [5:0] a0, input logic [7:0] d0,
                              input logic r1, input logic [5:0] a1, input logic [7:0] d1,
                              input logic e0, input logic e1);
    vec_t v;
    v.name = name; v.r0 = r0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.a1 = a1; v.d1 = d1; v.e_ack0 = e0; v.e_ack1 = e1;
    return v;
  endfunction

  task automatic fill_model(input logic [7:0] val);
    for (int i = 0; i < 64; i++) model_mem[i] = val;
  endtask

  task automatic pop_read(input string name);
    logic [7:0] exp;
    if (rd_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: got 0x%0h expected scoreboard entry (queue empty)", name, charOutput);
    end else begin
      exp = rd_q.pop_front();
      check(name, 32'(charOutput), 32'(exp));
    end
  endtask

  // Sweeps every address; expectation pushed when the address is driven,
  // popped one edge later when the registered read data appears.
  task automatic read_all(input string tag);
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      if (i > 0) pop_read($sformatf("%s rd[%0d]", tag, i - 1));
      charAddress = 6'(i);
      rd_q.push_back(model_mem[i]);
    end
    @(posedge clk); #1;
    pop_read($sformatf("%s rd[63]", tag));
  endtask

  // Called at a sample point where busy is expected high. Counts busy cycles
  // (bounded) and acks seen inside the clear; optionally re-pulses clearReq.
  task automatic count_busy(input string tag, input bit skip_first_ack, input int re_req_at);
    int n;
    int acks;
    n    = 0;
    acks = 0;
    while (busy === 1'b1 && n < 200) begin
      if (!(skip_first_ack && n == 0)) acks += int'(ack0) + int'(ack1);
      clearReq = (n == re_req_at);
      n++;
      @(posedge clk); #1;
    end
    clearReq = 1'b0;
    check({tag, " busy cycles"}, 32'(n), 32'd64);
    check({tag, " acks during clear"}, 32'(acks), 32'd0);
  endtask

  task automatic apply_reset(input string tag);
    resetn   = 1'b0;
    req0     = 1'b0;
    req1     = 1'b0;
    clearReq = 1'b0;
    #2;
    check({tag, " busy in reset"}, 32'(busy), 32'd1);
    check({tag, " charOutput in reset"}, 32'(charOutput), 32'h00);
    check({tag, " ack0 in reset"}, 32'(ack0), 32'd0);
    check({tag, " ack1 in reset"}, 32'(ack1), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    resetn      = 1'b1;
    charAddress = '0;
    clearReq    = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    addr0 = '0;  addr1 = '0;
    data0 = '0;  data1 = '0;

    // Tie from reset, double-grant guard, boundary cells 0 and 63.
    vecs.push_back(mk("tie0",  1, 6'd2,  8'h30, 1, 6'd2,  8'h31, 1, 0));
    vecs.push_back(mk("tie1",  1, 6'd2,  8'h30, 1, 6'd2,  8'h31, 0, 1));
    vecs.push_back(mk("tie2",  1, 6'd2,  8'h30, 1, 6'd2,  8'h31, 1, 0));
    vecs.push_back(mk("tie3",  1, 6'd2,  8'h30, 1, 6'd2,  8'h31, 0, 1));
    vecs.push_back(mk("tie4",  1, 6'd9,  8'h40, 1, 6'd10, 8'h41, 1, 0));
    vecs.push_back(mk("tie5",  1, 6'd9,  8'h40, 1, 6'd10, 8'h41, 0, 1));
    vecs.push_back(mk("solo0", 1, 6'd11, 8'h42, 0, 6'd0,  8'h00, 1, 0));
    vecs.push_back(mk("held0", 1, 6'd11, 8'h42, 0, 6'd0,  8'h00, 0, 0));
    vecs.push_back(mk("re0",   1, 6'd11, 8'h42, 0, 6'd0,  8'h00, 1, 0));
    vecs.push_back(mk("idle0", 0, 6'd0,  8'h00, 0, 6'd0,  8'h00, 0, 0));
    vecs.push_back(mk("wrA",   1, 6'd17, 8'h41, 0, 6'd0,  8'h00, 1, 0));
    vecs.push_back(mk("idle1", 0, 6'd0,  8'h00, 0, 6'd0,  8'h00, 0, 0));
    vecs.push_back(mk("c63",   0, 6'd0,  8'h00, 1, 6'd63, 8'h7e, 0, 1));
    vecs.push_back(mk("held1", 0, 6'd0,  8'h00, 1, 6'd0,  8'h01, 0, 0));
    vecs.push_back(mk("c0",    0, 6'd0,  8'h00, 1, 6'd0,  8'h01, 0, 1));
    vecs.push_back(mk("idle2", 0, 6'd0,  8'h00, 0, 6'd0,  8'h00, 0, 0));

    #1;

    // Reset release with a request held off through the clear.
    apply_reset("reset");
    req0 = 1'b1; addr0 = 6'd40; data0 = 8'h55;
    count_busy("reset", 1'b0, -1);
    check("holdoff ack0 at RUN entry", 32'(ack0), 32'd0);
    @(posedge clk); #1;
    check("holdoff ack0 after clear", 32'(ack0), 32'd1);
    req0 = 1'b0;
    @(posedge clk); #1;
    check("holdoff ack0 one cycle", 32'(ack0), 32'd0);
    fill_model(8'h20);
    model_mem[40] = 8'h55;
    read_all("post-reset");

    // Arbitration vector table from a fresh reset.
    apply_reset("reset2");
    count_busy("reset2", 1'b0, -1);
    fill_model(8'h20);
    foreach (vecs[i]) begin
      req0 = vecs[i].r0; addr0 = vecs[i].a0; data0 = vecs[i].d0;
      req1 = vecs[i].r1; addr1 = vecs[i].a1; data1 = vecs[i].d1;
      @(posedge clk); #1;
      check({vecs[i].name, " ack0"}, 32'(ack0), 32'(vecs[i].e_ack0));
      check({vecs[i].name, " ack1"}, 32'(ack1), 32'(vecs[i].e_ack1));
      check({vecs[i].name, " busy"}, 32'(busy), 32'd0);
      if (vecs[i].e_ack0) model_mem[vecs[i].a0] = vecs[i].d0;
      if (vecs[i].e_ack1) model_mem[vecs[i].a1] = vecs[i].d1;
    end
    req0 = 1'b0; req1 = 1'b0;
    read_all("vectors");

    // Read-first on cell 5.
    charAddress = 6'd5;
    req0 = 1'b1; addr0 = 6'd5; data0 = 8'h5a;
    @(posedge clk); #1;
    check("rf ack0", 32'(ack0), 32'd1);
    check("rf old data", 32'(charOutput), 32'(model_mem[5]));
    req0 = 1'b0;
    model_mem[5] = 8'h5a;
    @(posedge clk); #1;
    check("rf new data", 32'(charOutput), 32'h5a);
    check("rf ack0 drop", 32'(ack0), 32'd0);

    // Clear while req1 alone is pending: it wins and commits on that edge.
    // A second clearReq inside the clear must not restart it.
    req1 = 1'b1; addr1 = 6'd20; data1 = 8'h61; clearReq = 1'b1;
    @(posedge clk); #1;
    check("clrA ack1", 32'(ack1), 32'd1);
    check("clrA busy", 32'(busy), 32'd1);
    req1 = 1'b0;
    count_busy("clrA", 1'b1, 10);

    // Clear during a tie: port 0 wins (port 1 was last), port 1 waits out
    // the clear and is then granted.
    req0 = 1'b1; addr0 = 6'd30; data0 = 8'h70;
    req1 = 1'b1; addr1 = 6'd31; data1 = 8'h71; clearReq = 1'b1;
    @(posedge clk); #1;
    check("clrB ack0", 32'(ack0), 32'd1);
    check("clrB ack1 held", 32'(ack1), 32'd0);
    check("clrB busy", 32'(busy), 32'd1);
    req0 = 1'b0;
    count_busy("clrB", 1'b1, -1);
    check("clrB ack1 at RUN entry", 32'(ack1), 32'd0);
    @(posedge clk); #1;
    check("clrB ack1 after clear", 32'(ack1), 32'd1);
    req1 = 1'b0;
    fill_model(8'h20);
    model_mem[31] = 8'h71;
    read_all("after-clear");

    // Reset at clear cycle 30; cell 31 still holds 0x71 at that point.
    charAddress = 6'd31;
    clearReq = 1'b1;
    @(posedge clk); #1;
    clearReq = 1'b0;
    check("mid busy", 32'(busy), 32'd1);
    repeat (30) begin
      @(posedge clk); #1;
    end
    check("mid read during clear", 32'(charOutput), 32'h71);
    apply_reset("midclear");
    count_busy("midclear", 1'b0, -1);
    fill_model(8'h20);
    read_all("post-midclear");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
